// File: rtl/sm_rho_stream.sv
// Streaming Keccak rho step: LPC lanes per beat, one registered output stage, valid/ready on both sides.
// Optional SM_RHO_INV_EN adds an 'inv' input selecting inverse rho (right rotation) for a whole state.
module sm_rho_stream #(
  parameter int W   = 64,
  parameter int LPC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
`ifdef SM_RHO_INV_EN
  input  logic             inv,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LPC*W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LPC*W-1:0] out_data,
  output logic             out_last,
  output logic             err_sync
);

  localparam int NB = 25 / LPC;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  localparam logic [5:0] MASK = 6'(W - 1);
  localparam logic [5:0] WMOD = 6'(W);

  function automatic logic [5:0] rho_off(input logic [4:0] i);
    case (i)
      5'd0:  rho_off = 6'd0;   5'd1:  rho_off = 6'd1;   5'd2:  rho_off = 6'd62;
      5'd3:  rho_off = 6'd28;  5'd4:  rho_off = 6'd27;  5'd5:  rho_off = 6'd36;
      5'd6:  rho_off = 6'd44;  5'd7:  rho_off = 6'd6;   5'd8:  rho_off = 6'd55;
      5'd9:  rho_off = 6'd20;  5'd10: rho_off = 6'd3;   5'd11: rho_off = 6'd10;
      5'd12: rho_off = 6'd43;  5'd13: rho_off = 6'd25;  5'd14: rho_off = 6'd39;
      5'd15: rho_off = 6'd41;  5'd16: rho_off = 6'd45;  5'd17: rho_off = 6'd15;
      5'd18: rho_off = 6'd21;  5'd19: rho_off = 6'd8;   5'd20: rho_off = 6'd18;
      5'd21: rho_off = 6'd2;   5'd22: rho_off = 6'd61;  5'd23: rho_off = 6'd56;
      5'd24: rho_off = 6'd14;
      default: rho_off = 6'd0;
    endcase
  endfunction

  // Rotate left via a doubled copy so an amount of zero needs no special case.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [5:0] amt);
    logic [2*W-1:0] t;
    t = {x, x} << amt;
    return t[2*W-1:W];
  endfunction

  // Inverse rho is a left rotation by (W - r) mod W.
  function automatic logic [W-1:0] lane_rot(input logic [W-1:0] x, input logic [4:0] idx,
                                            input logic inv_en);
    logic [5:0] amt;
    amt = rho_off(idx) & MASK;
    amt = inv_en ? ((WMOD - amt) & MASK) : amt;
    return rotl(x, amt);
  endfunction

  logic [BW-1:0]    bcnt_r;
  logic             accept_s;
  logic             last_beat_s;
  logic             inv_eff_s;
  logic [LPC*W-1:0] rot_s;

  assign in_ready    = !out_valid || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign last_beat_s = (bcnt_r == BLAST);

`ifdef SM_RHO_INV_EN
  logic inv_r;

  assign inv_eff_s = (bcnt_r == '0) ? inv : inv_r;

  // Direction latched on beat 0 and held for the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_r <= 1'b0;
    end else if (clr) begin
      inv_r <= 1'b0;
    end else if (accept_s && (bcnt_r == '0)) begin
      inv_r <= inv;
    end else begin
      inv_r <= inv_r;
    end
  end
`else
  assign inv_eff_s = 1'b0;
`endif

  // Per-lane rotation of the incoming beat.
  always_comb begin
    rot_s = '0;
    for (int k = 0; k < LPC; k++) begin
      rot_s[k*W +: W] = lane_rot(in_data[k*W +: W], 5'(int'(bcnt_r) * LPC + k), inv_eff_s);
    end
  end

  // Output register, beat counter and sticky framing error; clr outranks an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_r    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_sync  <= 1'b0;
    end else if (clr) begin
      bcnt_r    <= '0;
      out_valid <= 1'b0;
      err_sync  <= 1'b0;
    end else if (accept_s) begin
      out_data  <= rot_s;
      out_last  <= last_beat_s;
      out_valid <= 1'b1;
      bcnt_r    <= last_beat_s ? '0 : bcnt_r + BW'(1);
      if (in_last != last_beat_s) begin
        err_sync <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm_rho_stream.sv
// Self-checking bench for sm_rho_stream: three instances (W,LPC) = (64,1), (8,5), (2,25),
// a lane-index/bit-level rho model with a one-beat output slot, and directed scenarios.
module tb_sm_rho_stream;

  logic         clk;
  logic         rst_n;
  logic         i_valid [3];
  logic         i_last  [3];
  logic         i_ordy  [3];
  logic         i_clr   [3];
  logic [319:0] i_data  [3];
  logic         o_valid [3];
  logic         o_last  [3];
  logic         o_irdy  [3];
  logic         o_err   [3];
  logic [319:0] o_data  [3];
  logic [63:0]  a_od;
  logic [39:0]  b_od;
  logic [49:0]  c_od;

  int ROFF [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                    41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  int WD [3] = '{64, 8, 2};
  int LP [3] = '{1, 5, 25};

  int n_vec = 0;
  int n_mis = 0;
  int tb_lane [3] = '{0, 0, 0};

  // model state: one outstanding output beat per instance
  logic         m_vld  [3];
  logic [319:0] m_d    [3];
  logic         m_l    [3];
  logic         m_err  [3];
  int           m_lane [3];
  logic [319:0] cap_d [3][0:511];
  logic         cap_l [3][0:511];
  int           ncap  [3] = '{0, 0, 0};

  sm_rho_stream #(.W(64), .LPC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(i_clr[0]),
`ifdef SM_RHO_INV_EN
    .inv(1'b0),
`endif
    .in_valid(i_valid[0]), .in_ready(o_irdy[0]), .in_data(i_data[0][63:0]), .in_last(i_last[0]),
    .out_valid(o_valid[0]), .out_ready(i_ordy[0]), .out_data(a_od), .out_last(o_last[0]),
    .err_sync(o_err[0]));

  sm_rho_stream #(.W(8), .LPC(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(i_clr[1]),
`ifdef SM_RHO_INV_EN
    .inv(1'b0),
`endif
    .in_valid(i_valid[1]), .in_ready(o_irdy[1]), .in_data(i_data[1][39:0]), .in_last(i_last[1]),
    .out_valid(o_valid[1]), .out_ready(i_ordy[1]), .out_data(b_od), .out_last(o_last[1]),
    .err_sync(o_err[1]));

  sm_rho_stream #(.W(2), .LPC(25)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(i_clr[2]),
`ifdef SM_RHO_INV_EN
    .inv(1'b0),
`endif
    .in_valid(i_valid[2]), .in_ready(o_irdy[2]), .in_data(i_data[2][49:0]), .in_last(i_last[2]),
    .out_valid(o_valid[2]), .out_ready(i_ordy[2]), .out_data(c_od), .out_last(o_last[2]),
    .err_sync(o_err[2]));

  assign o_data[0] = {256'd0, a_od};
  assign o_data[1] = {280'd0, b_od};
  assign o_data[2] = {270'd0, c_od};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-level rho: out bit z of lane i = in bit (z - r[i]) mod w.
  function automatic logic [319:0] rho_model(input logic [319:0] x, input int lane, input int w,
                                             input int l);
    logic [319:0] o;
    int r;
    o = '0;
    for (int k = 0; k < l; k++) begin
      r = ROFF[lane + k] % w;
      for (int z = 0; z < w; z++) o[k*w + z] = x[k*w + ((z - r + w) % w)];
    end
    return o;
  endfunction

  function automatic logic [319:0] rnd();
    logic [319:0] v;
    for (int j = 0; j < 10; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: consumes beats, holds one output beat, tracks lane index and framing error.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_vld[d] <= 1'b0; m_lane[d] <= 0; m_err[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (i_clr[d]) begin
          m_vld[d] <= 1'b0; m_lane[d] <= 0; m_err[d] <= 1'b0;
        end else begin
          if (m_vld[d] && i_ordy[d]) begin
            m_vld[d] <= 1'b0;
            if (ncap[d] < 512) begin
              cap_d[d][ncap[d]] <= o_data[d];
              cap_l[d][ncap[d]] <= o_last[d];
              ncap[d] <= ncap[d] + 1;
            end
          end
          if (i_valid[d] && (!m_vld[d] || i_ordy[d])) begin
            m_vld[d]  <= 1'b1;
            m_d[d]    <= rho_model(i_data[d], m_lane[d], WD[d], LP[d]);
            m_l[d]    <= (m_lane[d] + LP[d] == 25);
            m_lane[d] <= (m_lane[d] + LP[d]) % 25;
            if (i_last[d] != (m_lane[d] + LP[d] == 25)) m_err[d] <= 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d out_valid", d), 320'(o_valid[d]), 320'(m_vld[d]));
        chk($sformatf("d%0d in_ready", d), 320'(o_irdy[d]), 320'(!m_vld[d] || i_ordy[d]));
        chk($sformatf("d%0d err_sync", d), 320'(o_err[d]), 320'(m_err[d]));
        if (m_vld[d]) begin
          chk($sformatf("d%0d out_data", d), o_data[d], m_d[d]);
          chk($sformatf("d%0d out_last", d), 320'(o_last[d]), 320'(m_l[d]));
        end
      end
    end
  end

  task automatic send(input int d, input logic [319:0] data, input logic last, input bit bp);
    bit ok;
    bit rdy;
    ok = 1'b0;
    i_valid[d] = 1'b1; i_data[d] = data; i_last[d] = last;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (bp) i_ordy[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = o_irdy[d];
      @(posedge clk); #1;
      ok = rdy;
    end
    i_valid[d] = 1'b0;
    tb_lane[d] = (tb_lane[d] + LP[d]) % 25;
    if (!ok) chk($sformatf("d%0d accept timeout", d), 320'd0, 320'd1);
  endtask

  task automatic send_auto(input int d, input logic [319:0] data, input bit bp);
    send(d, data, (tb_lane[d] + LP[d] == 25), bp);
  endtask

  task automatic stream(input int d, input int n, input bit bp);
    for (int j = 0; j < n; j++) send_auto(d, rnd(), bp);
    i_ordy[d] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input int d, input bit with_beat);
    i_clr[d] = 1'b1;
    if (with_beat) begin
      i_valid[d] = 1'b1; i_data[d] = rnd(); i_last[d] = 1'b0;
    end
    @(posedge clk); #1;
    i_clr[d] = 1'b0; i_valid[d] = 1'b0; tb_lane[d] = 0;
  endtask

  initial begin
    int b0;
    int nl;
    logic [319:0] held;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      i_valid[d] = 1'b0; i_last[d] = 1'b0; i_ordy[d] = 1'b1; i_clr[d] = 1'b0; i_data[d] = '0;
    end

    // model pins
    chk("model lane1", rho_model(320'h1, 1, 64, 1), 320'h2);
    chk("model lane2", rho_model(320'h1, 2, 64, 1), 320'h4000_0000_0000_0000);
    chk("model w8 beat0", rho_model(320'h01_0101_0101, 0, 8, 5), 320'h08_1040_0201);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset valid", d), 320'(o_valid[d]), 320'd0);
      chk($sformatf("d%0d reset data", d), o_data[d], 320'd0);
      chk($sformatf("d%0d reset last", d), 320'(o_last[d]), 320'd0);
      chk($sformatf("d%0d reset err", d), 320'(o_err[d]), 320'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    chk("in_ready after reset", 320'(o_irdy[0]), 320'd1);

    // T1: 25 beats of 1, W=64 LPC=1
    b0 = ncap[0];
    for (int j = 0; j < 25; j++) send_auto(0, 320'h1, 1'b0);
    idle(3);
    chk("T1 beat count", 320'(ncap[0] - b0), 320'd25);
    chk("T1 lane0", cap_d[0][b0], 320'h1);
    chk("T1 lane1", cap_d[0][b0 + 1], 320'h2);
    chk("T1 lane2", cap_d[0][b0 + 2], 320'h4000_0000_0000_0000);
    chk("T1 last beat24", 320'(cap_l[0][b0 + 24]), 320'd1);
    nl = 0;
    for (int j = 0; j < 25; j++) nl += int'(cap_l[0][b0 + j]);
    chk("T1 last count", 320'(nl), 320'd1);

    // random full state with random backpressure
    stream(0, 25, 1'b1);
    idle(3);

    // T3: explicit backpressure
    b0 = ncap[0];
    i_ordy[0] = 1'b0;
    send_auto(0, rnd(), 1'b0);
    i_valid[0] = 1'b1; i_data[0] = rnd(); i_last[0] = 1'b0;
    @(negedge clk);
    held = o_data[0];
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      chk("T3 in_ready low", 320'(o_irdy[0]), 320'd0);
      chk("T3 data stable", o_data[0], held);
    end
    @(posedge clk); #1;
    i_ordy[0] = 1'b1;
    send_auto(0, i_data[0], 1'b0);
    stream(0, 23, 1'b0);
    idle(3);
    chk("T3 beat count", 320'(ncap[0] - b0), 320'd25);

    // clr with a simultaneous beat: beat dropped
    do_clr(0, 1'b1);
    idle(2);
    chk("clr drops beat", 320'(o_valid[0]), 320'd0);

    // T4: in_last on beat 3
    for (int j = 0; j < 3; j++) send(0, rnd(), 1'b0, 1'b0);
    chk("T4 err before", 320'(o_err[0]), 320'd0);
    send(0, rnd(), 1'b1, 1'b0);
    chk("T4 err set", 320'(o_err[0]), 320'd1);
    send(0, rnd(), 1'b0, 1'b0);
    chk("T4 err sticky", 320'(o_err[0]), 320'd1);
    do_clr(0, 1'b0);
    chk("T4 err cleared", 320'(o_err[0]), 320'd0);
    b0 = ncap[0];
    send_auto(0, 320'h8000_0000_0000_0001, 1'b0);
    idle(2);
    chk("T4 lane0 after clr", cap_d[0][b0], 320'h8000_0000_0000_0001);
    stream(0, 24, 1'b0);
    idle(2);

    // T5: reset after beat 10
    stream(0, 11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("T5 valid async", 320'(o_valid[0]), 320'd0);
    chk("T5 data async", o_data[0], 320'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int d = 0; d < 3; d++) tb_lane[d] = 0;
    idle(1);
    b0 = ncap[0];
    send_auto(0, 320'hF0, 1'b0);
    idle(2);
    chk("T5 lane0 identity", cap_d[0][b0], 320'hF0);
    stream(0, 24, 1'b0);
    idle(2);

    // T2: W=8 LPC=5
    b0 = ncap[1];
    send_auto(1, 320'h01_0101_0101, 1'b0);
    stream(1, 4, 1'b0);
    idle(3);
    chk("T2 beat0", cap_d[1][b0], 320'h08_1040_0201);
    nl = 0;
    for (int j = 0; j < 4; j++) nl += int'(cap_l[1][b0 + j]);
    chk("T2 no early last", 320'(nl), 320'd0);
    chk("T2 last beat4", 320'(cap_l[1][b0 + 4]), 320'd1);
    stream(1, 10, 1'b1);
    idle(3);

    // LPC=25: every beat is a whole state
    b0 = ncap[2];
    send(2, 320'h4, 1'b1, 1'b0);
    stream(2, 3, 1'b1);
    idle(3);
    chk("C lane1 rot", cap_d[2][b0], 320'h8);
    nl = 0;
    for (int j = 0; j < 4; j++) nl += int'(cap_l[2][b0 + j]);
    chk("C last every beat", 320'(nl), 320'd4);
    chk("C err clean", 320'(o_err[2]), 320'd0);
    send(2, rnd(), 1'b0, 1'b0);
    chk("C err on missing last", 320'(o_err[2]), 320'd1);
    do_clr(2, 1'b0);
    chk("C err cleared", 320'(o_err[2]), 320'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
